// File: rtl/traffic_sched.sv
// Two-street traffic light controller with a pedestrian all-red walk phase.
// Moore outputs decoded from the registered state; a 4-bit saturating timer paces each phase.
module traffic_sched #(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 12,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned WALK_T    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ta,
  input  logic       tb,
  input  logic       ped_req,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_AG   = 3'd0,
    S_AY   = 3'd1,
    S_BG   = 3'd2,
    S_BY   = 3'd3,
    S_WALK = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    L_GREEN  = 2'b00,
    L_YELLOW = 2'b01,
    L_RED    = 2'b10
  } light_e;

  typedef enum logic {
    DIR_A = 1'b0,
    DIR_B = 1'b1
  } dir_e;

  // Last timer value of each phase; the timer reads 0 in a phase's first cycle.
  localparam logic [3:0] GMIN_LAST = 4'(GREEN_MIN - 1);
  localparam logic [3:0] GMAX_LAST = 4'(GREEN_MAX - 1);
  localparam logic [3:0] YEL_LAST  = 4'(YELLOW_T - 1);
  localparam logic [3:0] WALK_LAST = 4'(WALK_T - 1);

  state_e     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic       ped_pend_q, ped_pend_d;
  dir_e       next_dir_q, next_dir_d;
  logic       ped_ack_q, ped_ack_d;
  logic       enter_walk;
  light_e     la_c, lb_c;

  // NOTE: every variable assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
    unique case (state_q)
      S_AG: begin
        if (timer_q >= GMIN_LAST && (tb || ped_pend_q) && (!ta || timer_q >= GMAX_LAST))
          state_d = S_AY;
      end
      S_AY: begin
        if (timer_q == YEL_LAST) begin
          if (ped_pend_q) begin
            state_d    = S_WALK;
            next_dir_d = DIR_B;
          end else begin
            state_d = S_BG;
          end
        end
      end
      S_BG: begin
        if (timer_q >= GMIN_LAST && (ta || ped_pend_q) && (!tb || timer_q >= GMAX_LAST))
          state_d = S_BY;
      end
      S_BY: begin
        if (timer_q == YEL_LAST) begin
          if (ped_pend_q) begin
            state_d    = S_WALK;
            next_dir_d = DIR_A;
          end else begin
            state_d = S_AG;
          end
        end
      end
      S_WALK: begin
        if (timer_q == WALK_LAST)
          state_d = (next_dir_q == DIR_A) ? S_AG : S_BG;
      end
      default: state_d = S_AG;
    endcase

    enter_walk = (state_d == S_WALK) && (state_q != S_WALK);

    // Entering WALK services the request, so the clear outranks a same-cycle set.
    ped_pend_d = ped_pend_q;
    if (enter_walk)
      ped_pend_d = 1'b0;
    else if (ped_req && state_q != S_WALK)
      ped_pend_d = 1'b1;

    ped_ack_d = enter_walk;

    if (state_d != state_q)
      timer_d = 4'd0;
    else if (timer_q == 4'hF)
      timer_d = timer_q;
    else
      timer_d = timer_q + 4'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_AG;
      timer_q    <= 4'd0;
      ped_pend_q <= 1'b0;
      next_dir_q <= DIR_B;
      ped_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
      next_dir_q <= next_dir_d;
      ped_ack_q  <= ped_ack_d;
    end
  end

  always_comb begin
    la_c = L_RED;
    lb_c = L_RED;
    walk = 1'b0;
    unique case (state_q)
      S_AG:    la_c = L_GREEN;
      S_AY:    la_c = L_YELLOW;
      S_BG:    lb_c = L_GREEN;
      S_BY:    lb_c = L_YELLOW;
      S_WALK:  walk = 1'b1;
      default: ;
    endcase
  end

  assign la      = la_c;
  assign lb      = lb_c;
  assign ped_ack = ped_ack_q;
  assign phase   = state_q;

endmodule

// File: tb/tb_traffic_sched.sv
// Directed bench for traffic_sched at default parameters; expected phase lengths are hand-derived.
module tb_traffic_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       ta, tb, ped_req;
  logic [1:0] la, lb;
  logic       walk, ped_ack;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;
  int acks;

  localparam logic [1:0] GRN = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] RED = 2'b10;

  traffic_sched dut (
    .clk     (clk),
    .reset   (reset),
    .ta      (ta),
    .tb      (tb),
    .ped_req (ped_req),
    .la      (la),
    .lb      (lb),
    .walk    (walk),
    .ped_ack (ped_ack),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling happens 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect phase code ph (with its light decoding) for exactly n consecutive cycles.
  task automatic expect_phase(input string tag, input logic [2:0] ph, input int n);
    logic [1:0] ela, elb;
    case (ph)
      3'd0:    begin ela = GRN; elb = RED; end
      3'd1:    begin ela = YEL; elb = RED; end
      3'd2:    begin ela = RED; elb = GRN; end
      3'd3:    begin ela = RED; elb = YEL; end
      default: begin ela = RED; elb = RED; end
    endcase
    for (int i = 0; i < n; i++) begin
      check({tag, "_phase"}, 8'(phase), 8'(ph));
      check({tag, "_la"}, 8'(la), 8'(ela));
      check({tag, "_lb"}, 8'(lb), 8'(elb));
      check({tag, "_walk"}, 8'(walk), 8'(ph == 3'd4));
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ta = 1'b1; tb = 1'b0; ped_req = 1'b0;
    tick();
    tick();
    check("rst_la", 8'(la), 8'(GRN));
    check("rst_lb", 8'(lb), 8'(RED));
    check("rst_walk", 8'(walk), 8'd0);
    check("rst_ack", 8'(ped_ack), 8'd0);
    check("rst_phase", 8'(phase), 8'd0);
    reset = 1'b0;
    expect_phase("idle_ag", 3'd0, 22);

    // B demand only: minimum green, then yellow, then B green
    do_reset();
    ta = 1'b0; tb = 1'b1;
    expect_phase("bdem_ag", 3'd0, 4);
    expect_phase("bdem_ay", 3'd1, 2);
    check("bdem_bg_phase", 8'(phase), 8'd2);
    check("bdem_bg_la", 8'(la), 8'(RED));
    check("bdem_bg_lb", 8'(lb), 8'(GRN));

    // Both streets busy: each green runs to its maximum
    do_reset();
    ta = 1'b1; tb = 1'b1;
    expect_phase("both_ag1", 3'd0, 12);
    expect_phase("both_ay1", 3'd1, 2);
    expect_phase("both_bg1", 3'd2, 12);
    expect_phase("both_by1", 3'd3, 2);
    expect_phase("both_ag2", 3'd0, 12);
    expect_phase("both_ay2", 3'd1, 2);
    check("both_bg2_phase", 8'(phase), 8'd2);

    // Pedestrian pulse in the 2nd AG cycle, no vehicle demand
    do_reset();
    ta = 1'b0; tb = 1'b0;
    expect_phase("ped_ag_c1", 3'd0, 1);
    ped_req = 1'b1;
    expect_phase("ped_ag_c2", 3'd0, 1);
    ped_req = 1'b0;
    expect_phase("ped_ag_c34", 3'd0, 2);
    expect_phase("ped_ay", 3'd1, 2);
    check("ped_w1_phase", 8'(phase), 8'd4);
    check("ped_w1_la", 8'(la), 8'(RED));
    check("ped_w1_lb", 8'(lb), 8'(RED));
    check("ped_w1_walk", 8'(walk), 8'd1);
    check("ped_w1_ack", 8'(ped_ack), 8'd1);
    tick();
    check("ped_w2_walk", 8'(walk), 8'd1);
    check("ped_w2_ack", 8'(ped_ack), 8'd0);
    tick();
    check("ped_w3_phase", 8'(phase), 8'd4);
    check("ped_w3_ack", 8'(ped_ack), 8'd0);
    tick();
    check("ped_bg_phase", 8'(phase), 8'd2);
    check("ped_bg_lb", 8'(lb), 8'(GRN));
    check("ped_bg_walk", 8'(walk), 8'd0);

    // ped_req held through a whole walk: one grant, then back to A green
    ped_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      acks += int'(ped_ack);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check("hold_walk_phase", 8'(phase), 8'd4);
      acks += int'(ped_ack);
      tick();
    end
    ped_req = 1'b0;
    check("hold_ack_count", 8'(acks), 8'd1);
    check("hold_after_phase", 8'(phase), 8'd0);
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      check("hold_no_rewalk", 8'(phase), 8'd0);
      acks += int'(ped_ack);
      tick();
    end
    check("hold_no_second_ack", 8'(acks), 8'd0);

    // Reset in the 2nd WALK cycle, with a request present at the reset edge
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    expect_phase("rw_ag", 3'd0, 1);
    expect_phase("rw_ay", 3'd1, 2);
    check("rw_w1_phase", 8'(phase), 8'd4);
    tick();
    check("rw_w2_phase", 8'(phase), 8'd4);
    ped_req = 1'b1;
    do_reset();
    ped_req = 1'b0;
    check("rw_phase", 8'(phase), 8'd0);
    check("rw_la", 8'(la), 8'(GRN));
    check("rw_lb", 8'(lb), 8'(RED));
    check("rw_walk", 8'(walk), 8'd0);
    check("rw_ack", 8'(ped_ack), 8'd0);
    check("rw_pend", 8'(dut.ped_pend_q), 8'd0);
    expect_phase("rw_hold_ag", 3'd0, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
